// File: rtl/mem_pkg.sv
// Shared types and constants for the main memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int RD_LAT_MAX = 4;
    // The counter holds at most RD_LAT_MAX-1.
    localparam int CNT_W = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM with write enable and registered read; contents are never reset.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384,
    parameter int IDX_W  = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Single-outstanding valid/ready memory controller with programmable read latency.
// Define MEM_BOUNDS_CHECK_EN to flag and suppress accesses at or above DEPTH.
module main_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16384,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              err_q;
    logic              accept;
    logic              req_err;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr;

    // A request coinciding with reset is never taken.
    assign accept = req_valid && req_ready && !reset;

`ifdef MEM_BOUNDS_CHECK_EN
    assign req_err = (32'(req_addr) >= 32'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    // High index bits only matter for the bounds check; otherwise the address wraps.
    assign unused_addr = ^req_addr;

    assign arr_we = accept && req_we && !req_err;
    // The array is read at acceptance; its output register then holds until the next read.
    assign arr_re = accept && !req_we;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (req_addr[IDX_W-1:0]),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // Data is exposed only while a read response is presented; writes and errors give 0.
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? arr_rdata : '0;
    assign rsp_err   = rsp_valid && err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        err_q     <= req_err;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_we || RD_LAT <= 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl with RD_LAT = 3 and DEPTH = 16384.
module tb_main_memory_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16384;
    localparam int RD_LAT = 3;
    localparam int TMO    = 20;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    main_memory_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_err   = exp_err;
        v.exp_lat   = we ? 1 : RD_LAT;
        return v;
    endfunction

    // Presents a request at a negedge where req_ready is high, then scrambles the fields after acceptance.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (n >= TMO) check("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
    endtask

    // Counts cycles from acceptance to rsp_valid, captures the response, then completes the handshake.
    task automatic take_rsp(output int lat, output logic [15:0] rdata, output logic err);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < TMO) begin
            lat++;
            @(negedge clk);
        end
        rdata     = rsp_rdata;
        err       = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;
        logic        seen;

        vecs[0]  = mk(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        vecs[1]  = mk(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        vecs[2]  = mk(1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0);
        vecs[3]  = mk(1'b1, 16'h0001, 16'h0F0F, 16'h0000, 1'b0);
        vecs[4]  = mk(1'b1, 16'h3FFF, 16'hA5C3, 16'h0000, 1'b0);
        vecs[5]  = mk(1'b0, 16'h3FFF, 16'h0000, 16'hA5C3, 1'b0);
        vecs[6]  = mk(1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0);
        vecs[7]  = mk(1'b1, 16'h4001, 16'h5A5A, 16'h0000, BC);
        vecs[8]  = mk(1'b0, 16'h0001, 16'h0000, BC ? 16'h0F0F : 16'h5A5A, 1'b0);
        vecs[9]  = mk(1'b0, 16'h4000, 16'h0000, BC ? 16'h0000 : 16'h1111, BC);
        vecs[10] = mk(1'b1, 16'h4000, 16'h1234, 16'h0000, BC);
        vecs[11] = mk(1'b0, 16'h0000, 16'h0000, BC ? 16'h1111 : 16'h1234, 1'b0);
        vecs[12] = mk(1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0);
        vecs[13] = mk(1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0);
        vecs[14] = mk(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        // rsp_ready is held high while idle; a later request must still wait its full latency.
        @(negedge clk);
        check("idle_rsp_ready_ignored", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            take_rsp(lat, rd, er);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rdata", i),   32'(rd),  32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_err", i),     32'(er),  32'(vecs[i].exp_err));
            @(negedge clk);
            check($sformatf("vec%0d_ready_after", i), 32'(req_ready), 32'd1);
        end

        // Backpressure: response held while a competing write is offered.
        issue(1'b0, 16'h0010, 16'h0000);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < TMO) begin
            lat++;
            @(negedge clk);
        end
        check("bp_latency", 32'(lat), 32'(RD_LAT));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'hDEAD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", c),     32'(rsp_rdata), 32'hBEEF);
            check($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_ready_after", 32'(req_ready), 32'd1);
        check("bp_busy_after",  32'(busy),      32'd0);
        issue(1'b0, 16'h0010, 16'h0000);
        take_rsp(lat, rd, er);
        check("bp_no_write_rdata", 32'(rd), 32'hBEEF);

        // Reset while the read is still in WAIT.
        issue(1'b0, 16'h3FFF, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        check("rst_mid_busy",      32'(busy),      32'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);
        issue(1'b0, 16'h3FFF, 16'h0000);
        take_rsp(lat, rd, er);
        check("rst_mid_reread_latency", 32'(lat), 32'(RD_LAT));
        check("rst_mid_reread_rdata",   32'(rd),  32'hA5C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Parametrised single-port main memory with a valid/ready request/response handshake, configurable read latency and optional address bounds checking. It replaces the fixed 16Ki x 16 always-enabled memory. The CPU's MAR/MBR datapath issues one request at a time, and every request (read or write) returns exactly one response. The block sits between the control unit's memory-access states and the storage array.

## Interface
Parameters:
- DATA_W, 16: data word width in bits.
- ADDR_W, 16: request address width; DEPTH must be <= 2**ADDR_W.
- DEPTH, 16384: number of words in the array.
- RD_LAT, 1: read latency in cycles from acceptance to rsp_valid, legal range 1..4.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_rdata  out  DATA_W  read data; 0 for write responses.
- rsp_err  out  1  out-of-range access (see Configuration).
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid && req_ready.
  - Write: the array is updated at the accept edge, then go to RESP.
  - Read with RD_LAT = 1: go to RESP with the data registered.
  - Read with RD_LAT > 1: go to WAIT with the latency counter loaded to RD_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle it reaches 0, rsp_rdata is loaded and the FSM goes to RESP.
  - The address and captured request are held internally; inputs are ignored.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are stable until the transfer.
  - On rsp_ready, go to IDLE.
- Exactly one outstanding request. req_ready = 0 in WAIT and RESP.
- Request fields are sampled only at the accept edge; later changes have no effect.
- Address arithmetic is unsigned. The array index is req_addr[$clog2(DEPTH)-1:0] when no bounds check is compiled in.
- Memory contents are not reset and are X until written.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, counter 0; req_ready 1 from the first cycle after reset.
- Read accepted at edge T: rsp_valid rises after edge T+RD_LAT-1, i.e. it is visible in cycle T+RD_LAT.
- Write accepted at edge T: array updated at T; rsp_valid visible in cycle T+1.
- A read of the address written by the previous request returns the new data.
- Response held at edge E with rsp_ready = 1: req_ready is high in the cycle after E. Minimum spacing between acceptances is RD_LAT+1 cycles (2 for writes).
- rsp_ready while rsp_valid = 0 is ignored.
- Reset mid-operation: a pending WAIT or RESP is discarded with no response; a write already committed to the array stays.
- Reset has priority over every other event in the same cycle.

## Configuration
- MEM_BOUNDS_CHECK_EN defined:
  - Any request with req_addr >= DEPTH sets rsp_err = 1.
  - A write is suppressed and the array is unchanged.
  - A read returns rsp_rdata = 0.
  - Timing is identical to an in-range access.
- MEM_BOUNDS_CHECK_EN undefined:
  - The address wraps modulo DEPTH through index truncation.
  - rsp_err is tied to 0.

## Structure
- Package mem_pkg holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - RD_LAT_MAX = 4;
  - the counter width localparam.
- Sub-module mem_array: a synchronous single-port RAM (DATA_W x DEPTH, write enable, registered read). The controller wraps it with the FSM, the latency counter and the bounds check.

## Test plan
- Reset then idle: req_ready = 1, rsp_valid = 0, busy = 0, rsp_rdata = 0.
- Write then read, RD_LAT = 3: write 0xBEEF to addr 0x0010 gives rsp_valid in cycle T+1 with rsp_err = 0. Read of 0x0010 gives rsp_valid exactly in cycle T+3 with rsp_rdata = 0xBEEF.
- Response backpressure: hold rsp_ready = 0 for 5 cycles after a read of 0xBEEF. rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted.
- Bounds, with MEM_BOUNDS_CHECK_EN and DEPTH = 16384:
  - write 0x1234 to 0x4000 gives rsp_err = 1;
  - read of 0x0000 still returns its prior value;
  - read of 0x4000 gives rsp_err = 1 and rsp_rdata = 0.
- Wrap, without the macro: write 0x5A5A to 0x4001, then read 0x0001; returns 0x5A5A with rsp_err = 0.
- Reset mid-read: assert reset in WAIT. No response follows and the FSM is in IDLE one cycle later. A subsequent read of the same address returns the correct data.
